video_dma_mover: RTL and testbench
==================================

// Module: video_dma_mover
// PURPOSE
//  Data-moving side of the video DMA: executes transfers while the DMA control asserts EXCT.
//  Requests the Z80 bus (BUSRQ/BUSAK), then copies bytes picture ROM -> video RAM, one per K2 slot.
//  Copies with auto-incrementing source/destination addresses and stops when its length count empties.
//  Hands the bus back to the CPU and reports completion with DONE.
// PARAMETERS
//  SRC_AW   16  picture-ROM address width
//  DST_AW   14  video-RAM address width
//  DW        8  data width
//  CNT_W    12  length counter width (max transfer 2^CNT_W-1 bytes)
//  RD_LAT    1  cycles from ROM_RD assertion to valid ROM_DATA (1..3)
// PORTS
//  CLK        in   1       system clock, all state on rising edge
//  RESET_AL   in   1       asynchronous active-low reset
//  EXCT       in   1       transfer window from DMA control, active high
//  K2         in   1       transfer-slot strobe, one CLK wide
//  SRC_LD     in   1       load SRC_IN into source counter
//  SRC_IN     in   SRC_AW  start source address
//  DST_LD     in   1       load DST_IN into destination counter
//  DST_IN     in   DST_AW  start destination address
//  LEN_LD     in   1       load LEN_IN into length counter
//  LEN_IN     in   CNT_W   byte count
//  BUSAK_AL   in   1       Z80 bus acknowledge, active low
//  ROM_DATA   in   DW      picture ROM read data
//  BUSRQ_AL   out  1       Z80 bus request, active low
//  ROM_RD     out  1       ROM read strobe
//  ROM_ADDR   out  SRC_AW  current source address
//  VRAM_WR    out  1       video RAM write strobe, one CLK
//  VRAM_ADDR  out  DST_AW  current destination address
//  VRAM_DATA  out  DW      byte being written
//  BUSY       out  1       high in any state other than IDLE
//  DONE       out  1       one-CLK completion pulse
//  REMAIN     out  CNT_W   live length counter
// BEHAVIOUR
//  Reset state: all outputs reset immediately while RESET_AL is low.
//  - BUSRQ_AL=1; ROM_RD, VRAM_WR, BUSY and DONE =0.
//  - Addresses, VRAM_DATA and REMAIN =0. FSM in IDLE.
//  Loads: *_LD take effect only in IDLE. In any other state they are ignored with no side effect.
//  Start: in IDLE, a 0->1 edge of EXCT (registered compare) starts a transfer.
//  - REMAIN==0: no bus request; DONE pulses on the next cycle; stay IDLE.
//  - REMAIN!=0: go to REQ.
//  FSM states: IDLE, REQ, SLOT, READ, WRITE, RELEASE.
//  REQ: BUSRQ_AL=0. Move to SLOT on the cycle after BUSAK_AL is sampled low.
//  - EXCT falling while in REQ -> RELEASE.
//  SLOT: wait for K2=1, then go to READ. EXCT low while in SLOT -> RELEASE.
//  READ: ROM_RD=1 for RD_LAT cycles. On the last of them, capture ROM_DATA into VRAM_DATA -> WRITE.
//  WRITE: VRAM_WR=1 for exactly one CLK, with VRAM_ADDR/VRAM_DATA stable. At the end of the cycle:
//  - source+1 and destination+1, each wrapping modulo 2^AW; REMAIN-1.
//  - Next state: REMAIN becomes 0 or EXCT low -> RELEASE; otherwise SLOT.
//  - An EXCT drop never aborts a READ/WRITE pair; the byte in flight always completes.
//  RELEASE: BUSRQ_AL=1. Wait for BUSAK_AL sampled high; then DONE=1 for one cycle and go to IDLE.
//  - Addresses and REMAIN are held, so a new EXCT edge resumes where the transfer stopped.
//  Throughput: at most one byte per K2 slot. Minimum per byte is 1 (SLOT) + RD_LAT + 1 (WRITE) CLKs.
//  - A K2 arriving while in READ or WRITE is not queued.
//  BUSAK_AL is never asserted without a request: if it goes low in IDLE it is ignored.
//  Reset mid-transfer: BUSRQ_AL is released asynchronously, and no partial write is issued.
// TESTING
//  1. SRC=0x1000, DST=0x0200, LEN=3, K2 every 4 CLK, BUSAK 2 CLK after BUSRQ ->
//     VRAM gets ROM[0x1000..1002] at 0x0200..0202, DONE once, REMAIN=0.
//  2. LEN=0, EXCT edge -> BUSRQ_AL stays 1, DONE pulses 1 CLK later, no VRAM_WR.
//  3. SRC=0xFFFF, DST=0x3FFF, LEN=2 -> second byte read from 0x0000 and written to 0x0000 (wrap).
//  4. LEN=5, EXCT dropped during the 2nd READ -> 2nd byte written, then RELEASE.
//     REMAIN=3 and DONE pulses; the next EXCT edge completes the remaining 3 bytes.
//  5. RESET_AL low during WRITE -> VRAM_WR, BUSRQ_AL and BUSY inactive in the same cycle; FSM IDLE.
//  6. SRC_LD with SRC_IN=0x2222 while BUSY -> ignored; ROM_ADDR continues from the old value.

Source files
------------

// File: rtl/video_dma_mover.sv
// Video DMA data mover: requests the Z80 bus and copies picture-ROM bytes into
// video RAM, one byte per K2 slot, while EXCT is held by the DMA control.
module video_dma_mover #(
  parameter int unsigned SRC_AW = 16,
  parameter int unsigned DST_AW = 14,
  parameter int unsigned DW     = 8,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET_AL,
  input  logic              EXCT,
  input  logic              K2,
  input  logic              SRC_LD,
  input  logic [SRC_AW-1:0] SRC_IN,
  input  logic              DST_LD,
  input  logic [DST_AW-1:0] DST_IN,
  input  logic              LEN_LD,
  input  logic [CNT_W-1:0]  LEN_IN,
  input  logic              BUSAK_AL,
  input  logic [DW-1:0]     ROM_DATA,
  output logic              BUSRQ_AL,
  output logic              ROM_RD,
  output logic [SRC_AW-1:0] ROM_ADDR,
  output logic              VRAM_WR,
  output logic [DST_AW-1:0] VRAM_ADDR,
  output logic [DW-1:0]     VRAM_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  REMAIN
);

  typedef enum logic [2:0] {IDLE, REQ, SLOT, READ, WRITE, RELEASE} state_t;

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic              exct_q;
  logic              start;
  logic              last_rd;
  logic              done_q, done_nx;
  logic [SRC_AW-1:0] src;
  logic [DST_AW-1:0] dst;
  logic [CNT_W-1:0]  len;
  logic [DW-1:0]     vdata;
  logic [1:0]        rd_cnt;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    start    = EXCT && !exct_q;
    last_rd  = (rd_cnt == RD_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) done_nx = 1'b1;
          else           state_nx = REQ;
        end
      end
      REQ: begin
        if (!EXCT)          state_nx = RELEASE;
        else if (!BUSAK_AL) state_nx = SLOT;
      end
      SLOT: begin
        if (!EXCT)   state_nx = RELEASE;
        else if (K2) state_nx = READ;
      end
      READ: begin
        if (last_rd) state_nx = WRITE;
      end
      WRITE: begin
        // The byte in flight always finishes; EXCT is only honoured here.
        if (len == CNT_W'(1) || !EXCT) state_nx = RELEASE;
        else                           state_nx = SLOT;
      end
      RELEASE: begin
        if (BUSAK_AL) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      state  <= IDLE;
      exct_q <= 1'b0;
      done_q <= 1'b0;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      vdata  <= '0;
      rd_cnt <= '0;
    end else begin
      state  <= state_nx;
      exct_q <= EXCT;
      done_q <= done_nx;
      if (state == IDLE) begin
        if (SRC_LD) src <= SRC_IN;
        if (DST_LD) dst <= DST_IN;
        if (LEN_LD) len <= LEN_IN;
      end
      if (state == READ) begin
        if (last_rd) begin
          vdata  <= ROM_DATA;
          rd_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + 2'd1;
        end
      end
      if (state == WRITE) begin
        src <= src + SRC_AW'(1);
        dst <= dst + DST_AW'(1);
        len <= len - CNT_W'(1);
      end
    end
  end

  // Strobes decode straight from the state so an async reset drops them at once.
  assign BUSRQ_AL  = !(state inside {REQ, SLOT, READ, WRITE});
  assign ROM_RD    = (state == READ);
  assign VRAM_WR   = (state == WRITE);
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign ROM_ADDR  = src;
  assign VRAM_ADDR = dst;
  assign VRAM_DATA = vdata;
  assign REMAIN    = len;

endmodule

// File: tb/tb_video_dma_mover.sv
// Bench for video_dma_mover: expected VRAM writes are queued by the stimulus and
// popped by a write monitor; control outputs are checked directly.
module tb_video_dma_mover;

  logic        CLK = 1'b0;
  logic        RESET_AL = 1'b0;
  logic        EXCT = 1'b0;
  logic        K2 = 1'b0;
  logic        SRC_LD = 1'b0;
  logic [15:0] SRC_IN = '0;
  logic        DST_LD = 1'b0;
  logic [13:0] DST_IN = '0;
  logic        LEN_LD = 1'b0;
  logic [11:0] LEN_IN = '0;
  logic        BUSAK_AL = 1'b1;
  logic [7:0]  ROM_DATA;
  logic        BUSRQ_AL, ROM_RD, VRAM_WR, BUSY, DONE;
  logic [15:0] ROM_ADDR;
  logic [13:0] VRAM_ADDR;
  logic [7:0]  VRAM_DATA;
  logic [11:0] REMAIN;

  video_dma_mover #(.SRC_AW(16), .DST_AW(14), .DW(8), .CNT_W(12), .RD_LAT(1)) dut (
    .CLK(CLK), .RESET_AL(RESET_AL), .EXCT(EXCT), .K2(K2),
    .SRC_LD(SRC_LD), .SRC_IN(SRC_IN), .DST_LD(DST_LD), .DST_IN(DST_IN),
    .LEN_LD(LEN_LD), .LEN_IN(LEN_IN), .BUSAK_AL(BUSAK_AL), .ROM_DATA(ROM_DATA),
    .BUSRQ_AL(BUSRQ_AL), .ROM_RD(ROM_RD), .ROM_ADDR(ROM_ADDR), .VRAM_WR(VRAM_WR),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .BUSY(BUSY), .DONE(DONE),
    .REMAIN(REMAIN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign ROM_DATA = rom(ROM_ADDR);

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  bit  busrq_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] s, input logic [13:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = d + 14'(i);
      w.d = rom(s + 16'(i));
      exp_q.push_back(w);
    end
  endtask

  // Bus arbiter model: BUSAK follows BUSRQ after 2 CLK, releases after 1 CLK.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (!BUSRQ_AL) cnt++; else cnt = 0;
      BUSAK_AL = !(cnt >= 2);
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge CLK); #1;
      ph++;
      K2 = (ph % 4 == 0);
    end
  end

  // Write monitor / scoreboard.
  always @(negedge CLK) begin
    if (RESET_AL) begin
      if (!BUSRQ_AL) busrq_seen = 1'b1;
      if (DONE) done_cnt++;
      if (VRAM_WR) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 32'(VRAM_ADDR), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(VRAM_ADDR), 32'(w.a));
          chk("wr_data", 32'(VRAM_DATA), 32'(w.d));
        end
      end
    end
  end

  task automatic load(input logic [15:0] s, input logic [13:0] d, input logic [11:0] n);
    @(posedge CLK); #1;
    SRC_IN = s; DST_IN = d; LEN_IN = n;
    SRC_LD = 1'b1; DST_LD = 1'b1; LEN_LD = 1'b1;
    @(posedge CLK); #1;
    SRC_LD = 1'b0; DST_LD = 1'b0; LEN_LD = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (DONE) got = 1'b1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic run(input string name);
    int d0;
    d0 = done_cnt;
    @(posedge CLK); #1;
    EXCT = 1'b1;
    wait_done(name);
    @(posedge CLK); #1;
    EXCT = 1'b0;
    repeat (3) @(posedge CLK);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    bit got;
    #23;
    chk("rst_busrq", 32'(BUSRQ_AL), 32'd1);
    chk("rst_rom_rd", 32'(ROM_RD), 32'd0);
    chk("rst_vram_wr", 32'(VRAM_WR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_addrs", {ROM_ADDR, 2'b00, VRAM_ADDR}, 32'd0);
    chk("rst_data_remain", {12'd0, VRAM_DATA, REMAIN}, 32'd0);
    @(negedge CLK);
    RESET_AL = 1'b1;

    // 1: basic three-byte copy
    load(16'h1000, 14'h0200, 12'd3);
    exp_push(16'h1000, 14'h0200, 3);
    run("t1");
    chk("t1_remain", 32'(REMAIN), 32'd0);
    chk("t1_rom_addr", 32'(ROM_ADDR), 32'h1003);
    chk("t1_vram_addr", 32'(VRAM_ADDR), 32'h0203);

    // 2: zero length completes without touching the bus
    load(16'h1000, 14'h0200, 12'd0);
    busrq_seen = 1'b0;
    d0 = done_cnt;
    @(posedge CLK); #1;
    EXCT = 1'b1;
    @(negedge CLK);
    chk("t2_done_early", 32'(DONE), 32'd0);
    @(negedge CLK);
    chk("t2_done_pulse", 32'(DONE), 32'd1);
    chk("t2_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk("t2_done_width", 32'(DONE), 32'd0);
    #1; EXCT = 1'b0;
    repeat (3) @(posedge CLK);
    chk("t2_no_busrq", 32'(busrq_seen), 32'd0);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // 3: address wrap on both counters
    load(16'hFFFF, 14'h3FFF, 12'd2);
    exp_push(16'hFFFF, 14'h3FFF, 1);
    exp_push(16'h0000, 14'h0000, 1);
    run("t3");
    chk("t3_rom_addr", 32'(ROM_ADDR), 32'h0001);

    // 4: EXCT dropped during 2nd READ, then resumed
    load(16'h0400, 14'h0100, 12'd5);
    exp_push(16'h0400, 14'h0100, 2);
    d0 = done_cnt;
    @(posedge CLK); #1;
    EXCT = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (ROM_RD && REMAIN == 12'd4) got = 1'b1;
    end
    chk("t4_second_read", 32'(got), 32'd1);
    EXCT = 1'b0;
    wait_done("t4a");
    repeat (3) @(posedge CLK);
    chk("t4_remain", 32'(REMAIN), 32'd3);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t4_q_drained", 32'(exp_q.size()), 32'd0);
    exp_push(16'h0402, 14'h0102, 3);
    run("t4b");
    chk("t4_remain_end", 32'(REMAIN), 32'd0);

    // 6: load while busy is ignored
    load(16'h3000, 14'h0300, 12'd3);
    exp_push(16'h3000, 14'h0300, 3);
    @(posedge CLK); #1;
    EXCT = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (BUSY) got = 1'b1;
    end
    chk("t6_busy", 32'(got), 32'd1);
    @(posedge CLK); #1;
    SRC_IN = 16'h2222; SRC_LD = 1'b1;
    @(posedge CLK); #1;
    SRC_LD = 1'b0;
    wait_done("t6");
    #1; EXCT = 1'b0;
    repeat (3) @(posedge CLK);
    chk("t6_rom_addr", 32'(ROM_ADDR), 32'h3003);

    // 5: reset during WRITE
    load(16'h0800, 14'h0080, 12'd4);
    @(posedge CLK); #1;
    EXCT = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (ROM_RD) got = 1'b1;
    end
    chk("t5_read", 32'(got), 32'd1);
    @(posedge CLK); #1;
    chk("t5_in_write", 32'(VRAM_WR), 32'd1);
    RESET_AL = 1'b0;
    #1;
    chk("t5_vram_wr", 32'(VRAM_WR), 32'd0);
    chk("t5_busrq", 32'(BUSRQ_AL), 32'd1);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_remain", 32'(REMAIN), 32'd0);
    EXCT = 1'b0;
    @(negedge CLK);
    RESET_AL = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("t5_idle", 32'(BUSY), 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
